// File: rtl/step_seq_ctrl_if.sv
// Host-side control bundle for step_seq_ctrl: burst request/parameters in, status back.
interface step_seq_ctrl_if #(
  parameter int CNT_W  = 12,
  parameter int NREP_W = 8
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  t_rep;
  logic [CNT_W-1:0]  t_step;
  logic [NREP_W-1:0] n_rep;
  logic              busy;
  logic              done;
  logic              err;
  logic [NREP_W-1:0] rep_cnt;

  modport master (
    output start, abort, t_rep, t_step, n_rep,
    input  busy, done, err, rep_cnt
  );

  modport slave (
    input  start, abort, t_rep, t_step, n_rep,
    output busy, done, err, rep_cnt
  );
endinterface

// File: rtl/step_seq_ctrl.sv
// Load-step burst sequencer: drives c0/c1 through n_rep on/off cycles paced by tick.
// Define STEP_SEQ_ALT_EN to alternate c0 (even reps) and c1 (odd reps); otherwise c1 stays 0.
module step_seq_ctrl #(
  parameter int CNT_W  = 12,
  parameter int NREP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  step_seq_ctrl_if.slave   host,
  output logic             c0,
  output logic             c1
);

  typedef enum logic [2:0] {IDLE, ARM, ON, OFF, DONE} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [NREP_W-1:0] REP_ONE = NREP_W'(1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic [CNT_W-1:0]  t_rep_q, t_step_q;
  logic [NREP_W-1:0] n_rep_q;
  logic [NREP_W-1:0] rep_cnt, rep_nx;
  logic              err, err_nx;
  logic              busy, done;
  logic              c0_nx, c1_nx;
  logic              latch;
  logic              params_ok;

  assign params_ok = (host.t_step != '0) && (host.t_step < host.t_rep) && (host.n_rep != '0);

  always_comb begin
    state_nx = state;
    count_nx = count;
    rep_nx   = rep_cnt;
    err_nx   = err;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (host.start && !host.abort) begin
          latch = 1'b1;
          if (params_ok) begin
            err_nx   = 1'b0;
            rep_nx   = '0;
            state_nx = ARM;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ARM: begin
        if (tick) begin
          count_nx = '0;
          state_nx = ON;
        end
      end
      ON: begin
        if (tick) begin
          count_nx = count + CNT_ONE;
          if (count == t_step_q - CNT_ONE) state_nx = OFF;
        end
      end
      OFF: begin
        if (tick) begin
          count_nx = count + CNT_ONE;
          if (count == t_rep_q - CNT_ONE) begin
            count_nx = '0;
            rep_nx   = rep_cnt + REP_ONE;
            state_nx = (rep_cnt == n_rep_q - REP_ONE) ? DONE : ON;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Abort overrides any progress made this cycle; completed reps are kept.
    if (host.abort && state != IDLE) begin
      state_nx = IDLE;
      count_nx = count;
      rep_nx   = rep_cnt;
    end

`ifdef STEP_SEQ_ALT_EN
    c0_nx = (state_nx == ON) && !rep_nx[0];
    c1_nx = (state_nx == ON) &&  rep_nx[0];
`else
    c0_nx = (state_nx == ON);
    c1_nx = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rep_cnt <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c0      <= 1'b0;
      c1      <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      rep_cnt <= rep_nx;
      err     <= err_nx;
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == DONE);
      c0      <= c0_nx;
      c1      <= c1_nx;
    end
  end

  // Burst parameters are captured once per accepted request and need no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      t_rep_q  <= host.t_rep;
      t_step_q <= host.t_step;
      n_rep_q  <= host.n_rep;
    end
  end

  assign host.busy    = busy;
  assign host.done    = done;
  assign host.err     = err;
  assign host.rep_cnt = rep_cnt;

endmodule

// File: doc/step_seq_ctrl.md
# step_seq_ctrl

Burst sequencer for the SMPS load-step switches. It takes a start request with programmable repetition period, step on-time and repetition count, then drives the load-switch enables through that many step cycles. It reports busy/done/error back to the test host. It sits between the host control registers and the load-switch gate drivers, with all timing paced by the shared prescaler tick.

## Interface
- CNT_W, 12, width of period/on-time counters (one LSB = one tick).
- NREP_W, 8, width of repetition count.
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous and active-high.
- tick  in  1  single-cycle timebase enable; counters advance only when tick=1.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  single-cycle request; terminates any active burst.
- t_rep  in  CNT_W  repetition period in ticks (e.g. 4000 = 20 ms).
- t_step  in  CNT_W  step on-time in ticks (e.g. 1200 = 6 ms).
- n_rep  in  NREP_W  number of step cycles in the burst.
- busy  out  1  high in ARM/ON/OFF/DONE.
- done  out  1  one-cycle pulse on normal burst completion.
- err  out  1  sticky parameter error; cleared by the next accepted start or by reset.
- rep_cnt  out  NREP_W  completed repetitions in the current/last burst.
- c0  out  1  load-switch 0 enable.
- c1  out  1  load-switch 1 enable.

## Operation
- States: IDLE, ARM, ON, OFF, DONE. All outputs are registered. c0/c1 are flops, never decoded combinationally.
- Reset values: state=IDLE, count=0, rep_cnt=0, busy=0, done=0, err=0, c0=0, c1=0.
- IDLE, start=1, abort=0:
  - Latch t_rep, t_step and n_rep into internal registers. Inputs may change afterwards without effect.
  - Validity check: t_step≠0, t_step<t_rep and n_rep≠0.
  - Invalid: err<=1, stay IDLE.
  - Valid: err<=0, rep_cnt<=0, go to ARM.
- ARM: wait for tick; on tick, count<=0 and go to ON. This aligns the burst to the timebase.
- ON: on tick, count<=count+1; when count==t_step-1, go to OFF.
- OFF: on tick, count<=count+1; when count==t_rep-1:
  - count<=0 and rep_cnt<=rep_cnt+1.
  - If rep_cnt==n_rep-1, go to DONE; else go to ON.
- DONE: done=1 for exactly one cycle, then go to IDLE. rep_cnt holds its final value.
- c0 is high exactly while state==ON. Result: on-time = t_step ticks, period = t_rep ticks.
- abort=1 in ARM/ON/OFF/DONE: next cycle state=IDLE, c0=c1=0, busy=0, no done pulse. rep_cnt holds the reps completed so far.
- Simultaneous events:
  - start and abort in IDLE: abort wins and start is ignored.
  - start while busy: ignored.
  - abort in IDLE: no effect.
- Counter arithmetic is unsigned CNT_W, with compares against latched values. The count cannot wrap because t_step<t_rep≤2^CNT_W−1.

## Timing
- Latency: start accepted at cycle N gives busy=1 at N+1. If tick=1 at N+1, c0 rises at N+2.
- tick held low freezes count and state. Outputs hold their values.
- done falls and busy falls on the same edge (cycle after DONE).
- rst asserted at any time clears all outputs asynchronously; deassertion resumes in IDLE.

## Configuration
- STEP_SEQ_ALT_EN defined: ON state drives c0 on even repetitions (rep_cnt[0]=0) and c1 on odd repetitions, alternating the two load switches. Never both high at once.
- Not defined: c0 is driven on every repetition and c1 is tied to 0.

## Test plan
- Normal burst, tick=1 every cycle, t_rep=10, t_step=3, n_rep=2, start at cycle 0:
  - busy high cycles 1–22.
  - c0 high cycles 2–4 and 12–14.
  - done high at cycle 22 only.
  - rep_cnt=1 at 12 and 2 at 22.
- Parameter error: t_rep=10, t_step=10, n_rep=1, start → err=1 next cycle, busy stays 0, c0 stays 0. A following valid start clears err.
- Abort: same stimulus as the normal burst, abort at cycle 3 → c0=0 and busy=0 at cycle 4, done never pulses, rep_cnt=0.
- Tick pacing: tick every 4th cycle, t_rep=4, t_step=1, n_rep=1 → c0 width exactly 4 clk cycles, period 16 clk cycles, start during busy ignored.
- Reset mid-ON: assert rst during c0=1 → c0, busy and rep_cnt are 0 immediately without waiting for a clock edge. After release, start relaunches the burst normally.
- STEP_SEQ_ALT_EN build, n_rep=3 → c0, c1, c0 on successive reps, never overlapping. Without the macro, c1=0 throughout.
